// File: rtl/epd_filter.sv
// rtl/epd_filter.sv - byte-stream Ethernet frame parser with address filter, classifier and counters
module epd_filter #(
    parameter int PREAMBLE_LEN = 8,
    parameter int MIN_PAYLOAD  = 46,
    parameter int MAX_PAYLOAD  = 1500,
    parameter int CNT_WIDTH    = 8,
    parameter bit SATURATE     = 1'b1,
    parameter bit LEN_CHECK    = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [7:0]           data,
    input  logic                 control,
    input  logic [47:0]          my_addr,
    input  logic                 promisc,
    output logic                 preamble_valid,
    output logic                 dst_addr_valid,
    output logic                 src_addr_valid,
    output logic                 type_length_valid,
    output logic                 packet_size_valid,
    output logic                 addr_match,
    output logic                 frame_done,
    output logic                 frame_good,
    output logic [2:0]           err_code,
    output logic [CNT_WIDTH-1:0] valid_packet_counter,
    output logic [CNT_WIDTH-1:0] error_packet_counter
);
    localparam int PW = $clog2(PREAMBLE_LEN + 1);
    localparam int CW = $clog2(MAX_PAYLOAD + 2);
    localparam logic [PW-1:0] SFD_CNT = PW'(PREAMBLE_LEN - 1);
    localparam logic [CW-1:0] PAY_MIN = CW'(MIN_PAYLOAD);
    localparam logic [CW-1:0] PAY_MAX = CW'(MAX_PAYLOAD);
    localparam logic [CW-1:0] PAY_SAT = CW'(MAX_PAYLOAD + 1);

    typedef enum logic [2:0] {IDLE, PREAMBLE, DST, SRC, TYPE, PAYLOAD, DROP} state_t;

    state_t        state, state_next;
    logic [PW-1:0] pre_cnt;
    logic [2:0]    fld_cnt;
    logic [CW-1:0] pay_cnt;
    logic [39:0]   dst_shift;
    logic [7:0]    tl_hi;
    logic [15:0]   tl;
    logic [2:0]    drop_err;
    logic          frame_start, frame_end;
    logic [2:0]    end_err, enter_err;
    logic [15:0]   tl_word;
    logic [47:0]   dst_word;
    logic          tl_bad_range, len_mismatch;

    // Field words as they complete on the current byte
    assign tl_word      = {tl_hi, data};
    assign dst_word     = {dst_shift, data};
    assign tl_bad_range = (tl_word > 16'h05DC) && (tl_word < 16'h0600);
    assign len_mismatch = LEN_CHECK && (tl <= 16'h05DC) && (tl != 16'(pay_cnt));

    function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] v);
        if (SATURATE && (v == {CNT_WIDTH{1'b1}})) return v;
        return v + CNT_WIDTH'(1);
    endfunction

    // State register
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next state, frame boundaries and end-of-frame classification
    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        frame_end   = 1'b0;
        end_err     = 3'd0;
        enter_err   = 3'd0;
        if (state != IDLE && !control) begin
            frame_end  = 1'b1;
            state_next = IDLE;
            case (state)
                DROP:    end_err = drop_err;
                PAYLOAD: begin
                    if (pay_cnt < PAY_MIN)      end_err = 3'd3;
                    else if (pay_cnt > PAY_MAX) end_err = 3'd4;
                    else if (len_mismatch)      end_err = 3'd5;
                    else if (!addr_match)       end_err = 3'd6;
                    else                        end_err = 3'd0;
                end
                default: end_err = 3'd2;
            endcase
        end else begin
            case (state)
                IDLE: begin
                    if (control && data == 8'h55) begin
                        state_next  = PREAMBLE;
                        frame_start = 1'b1;
                    end
                end
                PREAMBLE: begin
                    if (data == 8'hD5 && pre_cnt == SFD_CNT) begin
                        state_next = DST;
                    end else if (data != 8'h55 || pre_cnt == SFD_CNT) begin
                        state_next = DROP;
                        enter_err  = 3'd1;
                    end
                end
                DST:  if (fld_cnt == 3'd5) state_next = SRC;
                SRC:  if (fld_cnt == 3'd5) state_next = TYPE;
                TYPE: begin
                    if (fld_cnt == 3'd1) begin
                        if (tl_bad_range) begin
                            state_next = DROP;
                            enter_err  = 3'd5;
                        end else begin
                            state_next = PAYLOAD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Field capture, status flags, frame-end reporting and counters
    always_ff @(posedge clock) begin
        if (reset) begin
            preamble_valid       <= 1'b0;
            dst_addr_valid       <= 1'b0;
            src_addr_valid       <= 1'b0;
            type_length_valid    <= 1'b0;
            packet_size_valid    <= 1'b0;
            addr_match           <= 1'b0;
            frame_done           <= 1'b0;
            frame_good           <= 1'b0;
            err_code             <= 3'd0;
            valid_packet_counter <= '0;
            error_packet_counter <= '0;
            pre_cnt              <= '0;
            fld_cnt              <= 3'd0;
            pay_cnt              <= '0;
            dst_shift            <= '0;
            tl_hi                <= 8'h00;
            tl                   <= 16'h0000;
            drop_err             <= 3'd0;
        end else begin
            frame_done <= frame_end;
            frame_good <= frame_end && (end_err == 3'd0);
            if (frame_end) begin
                err_code          <= end_err;
                packet_size_valid <= (state == PAYLOAD) && (pay_cnt >= PAY_MIN) && (pay_cnt <= PAY_MAX);
                if (end_err == 3'd0)
                    valid_packet_counter <= bump(valid_packet_counter);
                else if (end_err <= 3'd5)
                    error_packet_counter <= bump(error_packet_counter);
            end
            if (frame_start) begin
                preamble_valid    <= 1'b0;
                dst_addr_valid    <= 1'b0;
                src_addr_valid    <= 1'b0;
                type_length_valid <= 1'b0;
                packet_size_valid <= 1'b0;
                addr_match        <= 1'b0;
                pre_cnt           <= PW'(1);
            end
            if (state_next == DROP && state != DROP) drop_err <= enter_err;
            if (control) begin
                case (state)
                    PREAMBLE: begin
                        pre_cnt <= pre_cnt + PW'(1);
                        if (state_next == DST) begin
                            preamble_valid <= 1'b1;
                            fld_cnt        <= 3'd0;
                        end
                    end
                    DST: begin
                        dst_shift <= dst_word[39:0];
                        fld_cnt   <= fld_cnt + 3'd1;
                        if (fld_cnt == 3'd5) begin
                            dst_addr_valid <= 1'b1;
                            addr_match     <= (dst_word == my_addr) || (dst_word == {48{1'b1}}) || promisc;
                            fld_cnt        <= 3'd0;
                        end
                    end
                    SRC: begin
                        fld_cnt <= fld_cnt + 3'd1;
                        if (fld_cnt == 3'd5) begin
                            src_addr_valid <= 1'b1;
                            fld_cnt        <= 3'd0;
                        end
                    end
                    TYPE: begin
                        tl_hi   <= data;
                        fld_cnt <= fld_cnt + 3'd1;
                        if (fld_cnt == 3'd1) begin
                            tl      <= tl_word;
                            fld_cnt <= 3'd0;
                            if (!tl_bad_range) begin
                                type_length_valid <= 1'b1;
                                pay_cnt           <= '0;
                            end
                        end
                    end
                    PAYLOAD: if (pay_cnt != PAY_SAT) pay_cnt <= pay_cnt + CW'(1);
                    default: ;
                endcase
            end
        end
    end
endmodule
